traffic_light_controller_nway: RTL
==================================

# traffic_light_controller_nway

Parametrised N-way traffic-light sequencer, successor to the fixed four-way controller. It cycles green, yellow and all-red phases over `NUM_WAYS` approaches. Green time is programmable per way at run time. An all-red clearance interval is inserted between approaches. A request-driven skip mode and an emergency all-red override are added. It sits at the top of the intersection datapath and drives lamp drivers directly.

## Interface
Parameters:
- `NUM_WAYS`, default 4: number of approaches, 2..16.
- `TW`, default 8: timer/duration width in bits.
- `YELLOW_TIME`, default 2: yellow duration in cycles.
- `ALLRED_TIME`, default 1: all-red clearance in cycles.
- `SKIP_IDLE`, default 0: 1 = skip ways whose `way_req` bit is low.
- `WW`: derived, equals max(1, clog2(`NUM_WAYS`)); not user-set.

Ports:
- `clk` in, 1 bit: single clock; all logic rises on posedge.
- `rst_n` in, 1 bit: asynchronous active-low reset.
- `green_time` in, `NUM_WAYS*TW` bits: green duration per way; way k uses bits [k*TW +: TW].
- `way_req` in, `NUM_WAYS` bits: demand per way; used only when `SKIP_IDLE`=1.
- `emerg` in, 1 bit: emergency override request, level-sensitive.
- `lights` out, `3*NUM_WAYS` bits: lamp code per way at [k*3 +: 3]. 3'b001 = green, 3'b010 = yellow, 3'b100 = red.
- `phase` out, 2 bits: 2'b00 ALL_RED, 2'b01 GREEN, 2'b10 YELLOW.
- `cur_way` out, `WW` bits: way currently or most recently served.

## Operation
- Registers:
  - state (ALL_RED/GREEN/YELLOW)
  - `TW`-bit timer
  - `cur_way`
  - latched green duration `gdur`
- Reset values:
  - state = ALL_RED, timer = 0, `cur_way` = `NUM_WAYS`-1, `gdur` = 1.
  - `lights` = 3'b100 on every way, `phase` = 2'b00.
- Effective duration: D = max(1, programmed value). A zero duration is treated as 1 cycle, including zero parameters.
- Each state lasts exactly D rising edges. The timer counts 0..D-1; on the edge where timer == D-1 the state advances and the timer clears to 0.
- ALL_RED, on its final cycle:
  - Selects the next way n, loads `cur_way` <= n, latches `gdur` <= max(1, green_time[n]) and enters GREEN.
  - `green_time` changes during GREEN have no effect until that way's next entry.
- Next-way selection:
  - `SKIP_IDLE`=0: n = (`cur_way`+1) mod `NUM_WAYS`.
  - `SKIP_IDLE`=1: n = first way with `way_req` high, searching `cur_way`+1, `cur_way`+2, … cyclically, with `cur_way` itself searched last.
  - `SKIP_IDLE`=1 with no requests: n = (`cur_way`+1) mod `NUM_WAYS`.
  - Wrap: from way `NUM_WAYS`-1 the next way is 0.
- GREEN: after `gdur` cycles, goes to YELLOW.
- YELLOW: after `YELLOW_TIME` cycles, goes to ALL_RED.
- Lamp outputs:
  - In GREEN or YELLOW, only way `cur_way` shows green or yellow; all other ways show 3'b100.
  - In ALL_RED, every way shows 3'b100.
  - No two ways are ever non-red simultaneously.
- Emergency:
  - `emerg` high in GREEN: the next edge enters YELLOW with timer 0; green is truncated. Yellow is never skipped.
  - `emerg` high in YELLOW: yellow completes normally.
  - ALL_RED with `emerg` high: state is held and the timer is held at 0.
  - `emerg` low again: full `ALLRED_TIME` elapses before next-way selection.
- Reset mid-operation: an immediate asynchronous return to all reset values. The lamps go all-red without passing through yellow.

## Timing
- `lights`, `phase` and `cur_way` are registered. They change only on the edge that changes state; no combinational path from inputs to outputs.
- `emerg` is sampled every edge, with 1 cycle latency from sampled high in GREEN to `phase`=YELLOW.
- `way_req` and `green_time` are sampled only on the ALL_RED final edge.
- Defaults with `green_time`=7 per way give one way cycle = 7+2+1 = 10 cycles, and a 40-cycle full rotation.
- First green after `rst_n` rises: way 0 on edge `ALLRED_TIME`. With defaults this is the first edge after reset release.

## Test plan
- Defaults, `green_time`=7 each:
  - Way 0 shows 001 for 7 cycles, then 010 for 2, then all 100 for 1, then way 1 green.
  - Way 3 wraps to way 0 at cycle 40.
  - Checker confirms at most one way non-red every cycle.
- Per-way durations green_time={0,3,1,255} (way0..3): way 0 green lasts 1 cycle, way 1 3 cycles, way 2 1 cycle, way 3 255 cycles.
- Mid-green `green_time` change: write way 2's value from 5 to 9 during way 2 green. The current green stays 5 cycles; the next visit lasts 9.
- `SKIP_IDLE`=1, `way_req`=4'b1001, start `cur_way`=0: sequence 0→3→0→3.
  - `way_req`=0 gives plain rotation.
  - Request only on `cur_way` reselects the same way after all-red.
- Emergency:
  - `emerg` pulse on the 3rd green cycle of way 1: YELLOW next edge, 2 yellow cycles, then all-red.
  - `emerg` held 20 cycles keeps all-red.
  - After release, exactly `ALLRED_TIME` cycles, then way 2 green.
- Reset mid-yellow: assert `rst_n` low asynchronously. All lamps go 100 immediately, `phase`=00, `cur_way`=`NUM_WAYS`-1. After release, way 0 green after `ALLRED_TIME`.

Source files
------------

// File: rtl/traffic_light_controller_nway.sv
// N-way traffic-light sequencer: GREEN -> YELLOW -> ALL_RED per approach, with
// per-way run-time green durations, optional request-driven skipping and an emergency all-red hold.
module traffic_light_controller_nway #(
    parameter int NUM_WAYS    = 4,
    parameter int TW          = 8,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    parameter int SKIP_IDLE   = 0,
    localparam int WW         = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_WAYS*TW-1:0] green_time,
    input  logic [NUM_WAYS-1:0]   way_req,
    input  logic                  emerg,
    output logic [3*NUM_WAYS-1:0] lights,
    output logic [1:0]            phase,
    output logic [WW-1:0]         cur_way
);

    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10
    } state_t;

    // Zero-length parameters are stretched to one cycle.
    localparam int YELLOW_D = (YELLOW_TIME < 1) ? 1 : YELLOW_TIME;
    localparam int ALLRED_D = (ALLRED_TIME < 1) ? 1 : ALLRED_TIME;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    state_t          state_reg;
    logic [TW-1:0]   timer_reg;
    logic [TW-1:0]   gdur_reg;
    logic [WW-1:0]   next_way;
    logic [TW-1:0]   gt_way [NUM_WAYS];
    logic [TW-1:0]   gt_sel;

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_gt
            assign gt_way[gi] = green_time[gi*TW +: TW];
        end
    endgenerate

    // Search starts one past the current way; the current way itself is visited last.
    always_comb begin
        logic found;
        found    = 1'b0;
        next_way = WW'((int'(cur_way) + 1) % NUM_WAYS);
        if (SKIP_IDLE != 0) begin
            for (int i = 1; i <= NUM_WAYS; i++) begin
                if (!found && way_req[(int'(cur_way) + i) % NUM_WAYS]) begin
                    next_way = WW'((int'(cur_way) + i) % NUM_WAYS);
                    found    = 1'b1;
                end
            end
        end
    end

    assign gt_sel = gt_way[next_way];
    assign phase  = state_reg;

    function automatic logic [3*NUM_WAYS-1:0] lamp_vec(input logic [WW-1:0] w,
                                                       input logic [2:0] code);
        logic [3*NUM_WAYS-1:0] v;
        v = {NUM_WAYS{LAMP_RED}};
        v[int'(w)*3 +: 3] = code;
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ALL_RED;
            timer_reg <= '0;
            gdur_reg  <= TW'(1);
            cur_way   <= WW'(NUM_WAYS - 1);
            lights    <= {NUM_WAYS{LAMP_RED}};
        end else begin
            case (state_reg)
                ALL_RED: begin
                    if (emerg) begin
                        timer_reg <= '0;
                    end else if (timer_reg == TW'(ALLRED_D - 1)) begin
                        state_reg <= GREEN;
                        timer_reg <= '0;
                        cur_way   <= next_way;
                        gdur_reg  <= (gt_sel == '0) ? TW'(1) : gt_sel;
                        lights    <= lamp_vec(next_way, LAMP_GREEN);
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                GREEN: begin
                    // Emergency truncates green but always passes through yellow.
                    if (emerg || timer_reg == gdur_reg - TW'(1)) begin
                        state_reg <= YELLOW;
                        timer_reg <= '0;
                        lights    <= lamp_vec(cur_way, LAMP_YELLOW);
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                YELLOW: begin
                    if (timer_reg == TW'(YELLOW_D - 1)) begin
                        state_reg <= ALL_RED;
                        timer_reg <= '0;
                        lights    <= {NUM_WAYS{LAMP_RED}};
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                default: begin
                    state_reg <= ALL_RED;
                    timer_reg <= '0;
                    lights    <= {NUM_WAYS{LAMP_RED}};
                end
            endcase
        end
    end

endmodule
